// File: rtl/apb_gpio_ng.sv
// APB GPIO controller: synchronised/filtered inputs, atomic output updates, sticky W1C interrupts.
// Define APB_GPIO_DEBOUNCE_EN to build the per-pin debounce filter (DBEN/DBCNT registers).
module apb_gpio_ng #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned NUM_GPIO       = 32,
  parameter int unsigned DEBOUNCE_W     = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_GPIO-1:0]       gpio_in,
  output logic [NUM_GPIO-1:0]       gpio_in_sync,
  output logic [NUM_GPIO-1:0]       gpio_out,
  output logic [NUM_GPIO-1:0]       gpio_dir,
  output logic                      interrupt
);

  localparam int unsigned N = NUM_GPIO;

  localparam logic [3:0] A_DIR   = 4'd0;
  localparam logic [3:0] A_IN    = 4'd1;
  localparam logic [3:0] A_OUT   = 4'd2;
  localparam logic [3:0] A_SET   = 4'd3;
  localparam logic [3:0] A_CLR   = 4'd4;
  localparam logic [3:0] A_TGL   = 4'd5;
  localparam logic [3:0] A_INTEN = 4'd6;
  localparam logic [3:0] A_TYPE0 = 4'd7;
  localparam logic [3:0] A_TYPE1 = 4'd8;
  localparam logic [3:0] A_STAT  = 4'd9;
  localparam logic [3:0] A_DBEN  = 4'd10;
  localparam logic [3:0] A_DBCNT = 4'd11;
  localparam logic [3:0] A_UNMAP = 4'd12;

  logic [3:0]            addr;
  logic                  wr_en;
  logic [N-1:0]          wdata;
  logic [N-1:0]          dir_q, out_q, inten_q, type0_q, type1_q, status_q;
  logic [N-1:0]          sync0_q, sync1_q, filt_q, filt_d_q;
  logic [N-1:0]          event_c, w1c_c;
  logic [N-1:0]          dben_rd;
  logic [DEBOUNCE_W-1:0] dbcnt_rd;
  logic [31:0]           rdata_c;
  logic                  unused_ok;

  assign addr      = PADDR[5:2];
  assign wr_en     = PSEL & PENABLE & PWRITE;
  assign wdata     = PWDATA[N-1:0];
  assign unused_ok = ^{PADDR, PWDATA};

  // Control and output registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dir_q   <= '0;
      out_q   <= '0;
      inten_q <= '0;
      type0_q <= '0;
      type1_q <= '0;
    end else if (wr_en) begin
      case (addr)
        A_DIR:   dir_q   <= wdata;
        A_OUT:   out_q   <= wdata;
        A_SET:   out_q   <= out_q | wdata;
        A_CLR:   out_q   <= out_q & ~wdata;
        A_TGL:   out_q   <= out_q ^ wdata;
        A_INTEN: inten_q <= wdata;
        A_TYPE0: type0_q <= wdata;
        A_TYPE1: type1_q <= wdata;
        default: ;
      endcase
    end
  end

  // Two-flop synchroniser plus delayed filtered value for edge detection
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync0_q  <= '0;
      sync1_q  <= '0;
      filt_d_q <= '0;
    end else begin
      sync0_q  <= gpio_in;
      sync1_q  <= sync0_q;
      filt_d_q <= filt_q;
    end
  end

`ifdef APB_GPIO_DEBOUNCE_EN
  logic [N-1:0]          dben_q;
  logic [DEBOUNCE_W-1:0] dbcnt_q;
  logic [DEBOUNCE_W-1:0] cnt_q [N];
  logic                  wr_dben, wr_dbcnt;

  assign wr_dben  = wr_en && (addr == A_DBEN);
  assign wr_dbcnt = wr_en && (addr == A_DBCNT);
  assign dben_rd  = dben_q;
  assign dbcnt_rd = dbcnt_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dben_q  <= '0;
      dbcnt_q <= '0;
    end else begin
      if (wr_dben)  dben_q  <= wdata;
      if (wr_dbcnt) dbcnt_q <= PWDATA[DEBOUNCE_W-1:0];
    end
  end

  // A change is accepted only after DBCNT+1 consecutive differing samples
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      filt_q <= '0;
      for (int i = 0; i < int'(N); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (!dben_q[i] || (sync1_q[i] == filt_q[i])) begin
          filt_q[i] <= sync1_q[i];
          cnt_q[i]  <= '0;
        end else if (cnt_q[i] == dbcnt_q) begin
          filt_q[i] <= sync1_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i]  <= cnt_q[i] + DEBOUNCE_W'(1);
        end
        if (wr_dbcnt || (wr_dben && !wdata[i])) cnt_q[i] <= '0;
      end
    end
  end
`else
  assign dben_rd  = '0;
  assign dbcnt_rd = '0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) filt_q <= '0;
    else          filt_q <= sync1_q;
  end
`endif

  // Per-pin event select: 00 level high, 01 level low, 10 rising, 11 falling
  always_comb begin
    event_c = (~type1_q & ~type0_q &  filt_q)
            | (~type1_q &  type0_q & ~filt_q)
            | ( type1_q & ~type0_q &  filt_q & ~filt_d_q)
            | ( type1_q &  type0_q & ~filt_q &  filt_d_q);
    w1c_c   = (wr_en && (addr == A_STAT)) ? wdata : '0;
  end

  // Sticky status: a new event beats a simultaneous W1C
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) status_q <= '0;
    else          status_q <= (status_q & ~w1c_c) | (inten_q & event_c);
  end

  always_comb begin
    rdata_c = '0;
    if (PSEL) begin
      case (addr)
        A_DIR:   rdata_c = 32'(dir_q);
        A_IN:    rdata_c = 32'(filt_q);
        A_OUT:   rdata_c = 32'(out_q);
        A_INTEN: rdata_c = 32'(inten_q);
        A_TYPE0: rdata_c = 32'(type0_q);
        A_TYPE1: rdata_c = 32'(type1_q);
        A_STAT:  rdata_c = 32'(status_q);
        A_DBEN:  rdata_c = 32'(dben_rd);
        A_DBCNT: rdata_c = 32'(dbcnt_rd);
        default: rdata_c = '0;
      endcase
    end
  end

  assign PRDATA       = rdata_c;
  assign PREADY       = 1'b1;
  assign PSLVERR      = PSEL & PENABLE & (addr >= A_UNMAP);
  assign gpio_in_sync = filt_q;
  assign gpio_out     = out_q;
  assign gpio_dir     = dir_q;
  assign interrupt    = |status_q;

endmodule

// File: tb/tb_apb_gpio_ng.sv
// Directed bench for apb_gpio_ng (8 pins): expected values queued on stimulus, popped at observation.
module tb_apb_gpio_ng;

  localparam int unsigned AW = 12;
  localparam int unsigned NG = 8;
  localparam int unsigned DW = 8;
  localparam logic [31:0] MASK = 32'h0000_00FF;

  localparam logic [11:0] R_DIR = 12'h00, R_IN = 12'h04, R_OUT = 12'h08, R_SET = 12'h0C;
  localparam logic [11:0] R_CLR = 12'h10, R_TGL = 12'h14, R_INTEN = 12'h18, R_TYPE0 = 12'h1C;
  localparam logic [11:0] R_TYPE1 = 12'h20, R_STAT = 12'h24, R_DBEN = 12'h28, R_DBCNT = 12'h2C;
  localparam logic [11:0] R_BAD = 12'h34;

`ifdef APB_GPIO_DEBOUNCE_EN
  localparam int LAT = 7;
  localparam logic [31:0] DBEN_EXP = 32'h1;
  localparam logic [31:0] GLITCH_EXP = 32'h0;
`else
  localparam int LAT = 3;
  localparam logic [31:0] DBEN_EXP = 32'h0;
  localparam logic [31:0] GLITCH_EXP = 32'h1;
`endif

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic [31:0]   PWDATA = '0;
  logic          PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
  logic [31:0]   PRDATA;
  logic          PREADY, PSLVERR, interrupt;
  logic [NG-1:0] gpio_in = '0;
  logic [NG-1:0] gpio_in_sync, gpio_out, gpio_dir;

  logic [31:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] rd, out_m;
  logic        err, seen;

  apb_gpio_ng #(.APB_ADDR_WIDTH(AW), .NUM_GPIO(NG), .DEBOUNCE_W(DW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .gpio_in(gpio_in), .gpio_in_sync(gpio_in_sync), .gpio_out(gpio_out),
    .gpio_dir(gpio_dir), .interrupt(interrupt)
  );

  always #5 HCLK = ~HCLK;

  task automatic expect_v(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed=%h but no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic e);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    #1;
    d = PRDATA;
    e = PSLVERR;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  initial begin
    // Reset state
    #1;
    expect_v(32'h0); check("rst_interrupt", 32'(interrupt));
    expect_v(32'h0); check("rst_gpio_out", 32'(gpio_out));
    cycles(3);
    HRESETn = 1'b1;
    expect_v(32'h1); check("pready", 32'(PREADY));
    expect_v(32'h0); apb_rd(R_DIR, rd, err); check("rst_dir", rd);
    expect_v(32'h0); apb_rd(R_OUT, rd, err); check("rst_out", rd);
    expect_v(32'h0); apb_rd(R_STAT, rd, err); check("rst_status", rd);
    expect_v(32'h0); check("rst_in_sync", 32'(gpio_in_sync));

    // Atomic output updates, modelled on an 8-bit register
    out_m = 32'h0000_00F0 & MASK;         apb_wr(R_OUT, 32'h0000_00F0);
    out_m = (out_m | 32'h0F) & MASK;      apb_wr(R_SET, 32'h0000_000F);
    out_m = (out_m & ~32'h30) & MASK;     apb_wr(R_CLR, 32'h0000_0030);
    out_m = (out_m ^ 32'h101) & MASK;     apb_wr(R_TGL, 32'h0000_0101);
    expect_v(out_m); apb_rd(R_OUT, rd, err); check("out_rd", rd);
    expect_v(out_m); check("gpio_out", 32'(gpio_out));
    expect_v(32'h0); apb_rd(R_SET, rd, err); check("wo_reads_zero", rd);
    expect_v(32'h0); check("mapped_no_slverr", 32'(err));

    // Pin-count masking and unmapped access
    apb_wr(R_DIR, 32'hFFFF_FFFF);
    expect_v(MASK); apb_rd(R_DIR, rd, err); check("dir_masked", rd);
    expect_v(MASK); check("gpio_dir", 32'(gpio_dir));
    expect_v(32'h0); apb_rd(R_BAD, rd, err); check("unmapped_prdata", rd);
    expect_v(32'h1); check("unmapped_slverr", 32'(err));
    expect_v(32'h0); check("idle_prdata", PRDATA);

    // Three-cycle synchroniser latency
    gpio_in[3] = 1'b1;
    cycles(2);
    expect_v(32'h0); check("sync_lat_2", 32'(gpio_in_sync[3]));
    cycles(1);
    expect_v(32'h1); check("sync_lat_3", 32'(gpio_in_sync[3]));
    expect_v(32'h08); apb_rd(R_IN, rd, err); check("in_rd", rd);

    // Debounce: glitch rejection and acceptance delay
    apb_wr(R_DBEN, 32'h1);
    apb_wr(R_DBCNT, 32'h4);
    expect_v(DBEN_EXP); apb_rd(R_DBEN, rd, err); check("dben_rd", rd);
    expect_v(32'h0); check("dben_no_slverr", 32'(err));
    seen = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (c == 0) gpio_in[0] = 1'b1;
      if (c == 4) gpio_in[0] = 1'b0;
      cycles(1);
      seen = seen | gpio_in_sync[0];
    end
    expect_v(GLITCH_EXP); check("glitch_4cyc", 32'(seen));
    cycles(4);
    gpio_in[0] = 1'b1;
    cycles(LAT - 1);
    expect_v(32'h0); check("pulse_before", 32'(gpio_in_sync[0]));
    cycles(1);
    expect_v(32'h1); check("pulse_accept", 32'(gpio_in_sync[0]));
    cycles(10 - LAT);
    gpio_in[0] = 1'b0;
    cycles(15);
    expect_v(32'h0); check("pulse_release", 32'(gpio_in_sync[0]));

    // Rising-edge interrupt on pin 2
    apb_wr(R_INTEN, 32'h04);
    apb_wr(R_TYPE1, 32'h04);
    gpio_in[2] = 1'b1;
    cycles(3);
    expect_v(32'h0); check("rise_irq_early", 32'(interrupt));
    cycles(1);
    expect_v(32'h1); check("rise_irq", 32'(interrupt));
    expect_v(32'h04); apb_rd(R_STAT, rd, err); check("rise_status", rd);
    apb_wr(R_STAT, 32'h04);
    expect_v(32'h0); check("w1c_irq_drop", 32'(interrupt));
    expect_v(32'h0); apb_rd(R_STAT, rd, err); check("w1c_status", rd);
    gpio_in[2] = 1'b0;
    cycles(6);
    gpio_in[2] = 1'b1;
    @(posedge HCLK); #1;
    apb_wr(R_STAT, 32'h04);
    expect_v(32'h1); check("event_beats_w1c", 32'(interrupt));
    expect_v(32'h04); apb_rd(R_STAT, rd, err); check("event_beats_w1c_st", rd);
    apb_wr(R_STAT, 32'h04);
    expect_v(32'h0); apb_rd(R_STAT, rd, err); check("rise_final_clear", rd);

    // Level-high interrupt on pin 5
    apb_wr(R_INTEN, 32'h20);
    apb_wr(R_TYPE1, 32'h00);
    gpio_in[5] = 1'b1;
    cycles(6);
    expect_v(32'h1); check("level_irq", 32'(interrupt));
    expect_v(32'h20); apb_rd(R_STAT, rd, err); check("level_status", rd);
    apb_wr(R_STAT, 32'h20);
    cycles(1);
    expect_v(32'h1); check("level_reassert", 32'(interrupt));
    expect_v(32'h20); apb_rd(R_STAT, rd, err); check("level_reassert_st", rd);
    gpio_in[5] = 1'b0;
    cycles(6);
    apb_wr(R_INTEN, 32'h00);
    expect_v(32'h1); check("inten_off_sticky", 32'(interrupt));
    apb_wr(R_STAT, 32'h20);
    expect_v(32'h0); check("level_cleared_irq", 32'(interrupt));
    expect_v(32'h0); apb_rd(R_STAT, rd, err); check("level_cleared_st", rd);

    // Asynchronous reset mid-operation
    apb_wr(R_INTEN, 32'h20);
    gpio_in[5] = 1'b1;
    cycles(6);
    expect_v(32'h1); check("pre_reset_irq", 32'(interrupt));
    #2 HRESETn = 1'b0;
    #1;
    expect_v(32'h0); check("mid_rst_irq", 32'(interrupt));
    expect_v(32'h0); check("mid_rst_out", 32'(gpio_out));
    expect_v(32'h0); check("mid_rst_dir", 32'(gpio_dir));
    expect_v(32'h0); check("mid_rst_in_sync", 32'(gpio_in_sync));
    cycles(2);
    HRESETn = 1'b1;
    cycles(2);
    expect_v(32'h0); check("post_rst_edge2", 32'(gpio_in_sync[3]));
    cycles(1);
    expect_v(32'h1); check("post_rst_edge3", 32'(gpio_in_sync[3]));

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: observed=%0d leftover entries expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
